muldiv_unit: RTL

- Iterative RV M-extension multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the Rs1/Rs2 operand values read in decode and the destination register address.
- Produces a result and destination tag for the writeback path, which drives Rd1/rd1Adr back into the register file.
- Accepts one operation at a time; the pipeline holds while Ready is low.

---
 rtl/muldiv_pkg.sv | 46 ++++
 rtl/muldiv_datapath.sv | 95 +++++++++
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Contents:
//   muldiv_op_t    - RV M-extension funct3 encodings
//   muldiv_state_t - control FSM states
//   is_div / is_rem / is_signed_a / is_signed_b - opcode classification
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // The low half of a product does not depend on signedness, so MUL is
    // grouped with the signed forms.
    function automatic logic is_signed_a(input muldiv_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shared shift/accumulate datapath for unsigned radix-2 multiply and
// restoring divide, plus the iteration down-counter.
// Ports:
//   clk, reset      - clock, async active-low reset
//   load            - capture magnitudes a_in/b_in and mode_div, start counter
//   step            - perform one iteration
//   mode_div        - 1 = divide (a_in / b_in), 0 = multiply (a_in * b_in)
//   a_in, b_in      - operand magnitudes
//   hi, lo          - product high/low halves
//   quotient, remainder - divide results
//   last            - the current step is the final iteration
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int BIT_COUNT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 mode_div,
    input  logic [BIT_COUNT-1:0] a_in,
    input  logic [BIT_COUNT-1:0] b_in,
    output logic [BIT_COUNT-1:0] hi,
    output logic [BIT_COUNT-1:0] lo,
    output logic [BIT_COUNT-1:0] quotient,
    output logic [BIT_COUNT-1:0] remainder,
    output logic                 last
);

    localparam int W  = BIT_COUNT;
    localparam int CW = $clog2(BIT_COUNT + 1);

    logic [W-1:0]  acc_q;
    logic [W-1:0]  shr_q;
    logic [W-1:0]  opd_q;
    logic [CW-1:0] cnt_q;
    logic          div_q;

    logic [W:0] mul_sum;
    logic [W:0] div_shift;
    logic [W:0] div_diff;

    // Multiply: multiplier sits in shr_q and shifts out LSB-first while the
    // product's high half accumulates in acc_q.
    assign mul_sum = shr_q[0] ? ({1'b0, acc_q} + {1'b0, opd_q}) : {1'b0, acc_q};

    // Divide: dividend shifts out of shr_q MSB-first into the partial
    // remainder; quotient bits shift into shr_q from the bottom. Since the
    // partial remainder is always below the divisor, diff[W] is the borrow.
    assign div_shift = {acc_q, shr_q[W-1]};
    assign div_diff  = div_shift - {1'b0, opd_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            shr_q <= '0;
            opd_q <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            acc_q <= '0;
            div_q <= mode_div;
            cnt_q <= CW'(BIT_COUNT);
            if (mode_div) begin
                shr_q <= a_in;
                opd_q <= b_in;
            end else begin
                shr_q <= b_in;
                opd_q <= a_in;
            end
        end else if (step) begin
            cnt_q <= cnt_q - 1'b1;
            if (div_q) begin
                if (!div_diff[W]) begin
                    acc_q <= div_diff[W-1:0];
                    shr_q <= {shr_q[W-2:0], 1'b1};
                end else begin
                    acc_q <= div_shift[W-1:0];
                    shr_q <= {shr_q[W-2:0], 1'b0};
                end
            end else begin
                acc_q <= mul_sum[W:1];
                shr_q <= {mul_sum[0], shr_q[W-1:1]};
            end
        end
    end

    assign hi        = acc_q;
    assign lo        = shr_q;
    assign quotient  = shr_q;
    assign remainder = acc_q;
    assign last      = (cnt_q == CW'(1));

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit (execute stage).
// Ports:
//   clk, reset          - clock, async active-low reset
//   Valid / Ready       - operation handshake; pipeline stalls while Ready=0
//   Op                  - funct3 (MUL..REMU)
//   Rs1, Rs2            - operands
//   RdAdrIn             - destination tag of the request
//   Flush               - synchronous abort, dominates Valid
//   ResultValid         - one-cycle result strobe
//   Result, RdAdrOut    - result value and its tag, held until next result
//
// state | meaning
// IDLE  | waiting for an operation, Ready=1
// CALC  | BIT_COUNT shift-add / shift-subtract iterations
// FIX   | sign correction and half/quotient/remainder select
// DONE  | ResultValid=1, Ready=1 (back-to-back accept allowed)
//
// Divide-by-zero and signed overflow skip CALC: their result is known at
// accept, and going through FIX gives them a fixed two-edge latency.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int BIT_COUNT      = 32,
    parameter int REGISTER_COUNT = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              Valid,
    output logic                              Ready,
    input  logic [2:0]                        Op,
    input  logic [BIT_COUNT-1:0]              Rs1,
    input  logic [BIT_COUNT-1:0]              Rs2,
    input  logic [$clog2(REGISTER_COUNT)-1:0] RdAdrIn,
    input  logic                              Flush,
    output logic                              ResultValid,
    output logic [BIT_COUNT-1:0]              Result,
    output logic [$clog2(REGISTER_COUNT)-1:0] RdAdrOut
);

    localparam int W  = BIT_COUNT;
    localparam int RW = $clog2(REGISTER_COUNT);

    muldiv_state_t state_q;
    muldiv_op_t    op_in;
    muldiv_op_t    op_q;
    logic [RW-1:0] tag_q;
    logic          neg_a_q;
    logic          neg_b_q;
    logic          fast_q;
    logic [W-1:0]  fast_res_q;
    logic          result_valid_q;
    logic [W-1:0]  result_q;
    logic [RW-1:0] rd_adr_q;

    logic          accept;
    logic          neg_a_in;
    logic          neg_b_in;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic          div_zero;
    logic          sig_ovf;
    logic          fast_in;
    logic [W-1:0]  fast_val;

    logic [W-1:0]   dp_hi;
    logic [W-1:0]   dp_lo;
    logic [W-1:0]   dp_quo;
    logic [W-1:0]   dp_rem;
    logic           dp_last;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   fixed_res;

    assign op_in  = muldiv_op_t'(Op);
    assign Ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept = Valid && Ready && !Flush;

    assign neg_a_in = is_signed_a(op_in) && Rs1[W-1];
    assign neg_b_in = is_signed_b(op_in) && Rs2[W-1];
    assign a_mag    = neg_a_in ? (-Rs1) : Rs1;
    assign b_mag    = neg_b_in ? (-Rs2) : Rs2;

    assign div_zero = is_div(op_in) && (Rs2 == '0);
    assign sig_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (Rs1 == {1'b1, {(W-1){1'b0}}}) && (Rs2 == '1);
    assign fast_in  = div_zero || sig_ovf;

    always_comb begin
        fast_val = '0;
        if (div_zero)
            fast_val = is_rem(op_in) ? Rs1 : '1;
        else if (sig_ovf)
            fast_val = is_rem(op_in) ? '0 : Rs1;
    end

    muldiv_datapath #(
        .BIT_COUNT(BIT_COUNT)
    ) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && !fast_in),
        .step      (state_q == ST_CALC),
        .mode_div  (is_div(op_in)),
        .a_in      (a_mag),
        .b_in      (b_mag),
        .hi        (dp_hi),
        .lo        (dp_lo),
        .quotient  (dp_quo),
        .remainder (dp_rem),
        .last      (dp_last)
    );

    // Quotient and product take the XOR of operand signs; the remainder
    // follows the dividend only (truncating division).
    assign prod     = {dp_hi, dp_lo};
    assign prod_fix = (neg_a_q ^ neg_b_q) ? (-prod) : prod;

    always_comb begin
        fixed_res = '0;
        if (fast_q) begin
            fixed_res = fast_res_q;
        end else begin
            case (op_q)
                OP_MUL:                       fixed_res = prod_fix[W-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: fixed_res = prod_fix[2*W-1:W];
                OP_DIV, OP_DIVU:              fixed_res = (neg_a_q ^ neg_b_q) ? (-dp_quo) : dp_quo;
                default:                      fixed_res = neg_a_q ? (-dp_rem) : dp_rem;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_MUL;
            tag_q          <= '0;
            neg_a_q        <= 1'b0;
            neg_b_q        <= 1'b0;
            fast_q         <= 1'b0;
            fast_res_q     <= '0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            rd_adr_q       <= '0;
        end else begin
            result_valid_q <= 1'b0;
            if (Flush) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (Valid) begin
                            op_q       <= op_in;
                            tag_q      <= RdAdrIn;
                            neg_a_q    <= neg_a_in;
                            neg_b_q    <= neg_b_in;
                            fast_q     <= fast_in;
                            fast_res_q <= fast_val;
                            state_q    <= fast_in ? ST_FIX : ST_CALC;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_CALC: begin
                        if (dp_last)
                            state_q <= ST_FIX;
                    end
                    ST_FIX: begin
                        state_q        <= ST_DONE;
                        result_valid_q <= 1'b1;
                        result_q       <= fixed_res;
                        rd_adr_q       <= tag_q;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ResultValid = result_valid_q;
    assign Result      = result_q;
    assign RdAdrOut    = rd_adr_q;

endmodule
